// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control FSM sequencing the shared multicycle RV32I datapath
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] immsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] resultsrc,
    output logic       adrsrc,
    output logic       memreq,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       trap
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam bit          TMO_EN   = (MEM_TIMEOUT > 0);
    localparam int unsigned TMO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    state_t      r_state;
    logic [31:0] r_tmo_cnt;
    logic        r_trap;
    logic        w_expired;
    logic [2:0]  w_alu_dec;

    assign w_expired = TMO_EN && (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_tmo_cnt <= '0;
            r_trap    <= 1'b0;
        end else begin
            case (r_state)
                // Memory states: mem_ready takes priority over an expiring wait.
                S_FETCH, S_MEMREAD, S_MEMWRITE: begin
                    if (mem_ready) begin
                        r_tmo_cnt <= '0;
                        case (r_state)
                            S_FETCH:   r_state <= S_DECODE;
                            S_MEMREAD: r_state <= S_MEMWB;
                            default:   r_state <= S_FETCH;
                        endcase
                    end else if (w_expired) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 32'd1;
                    end
                end
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_R:         r_state <= S_EXECR;
                        OP_I:         r_state <= S_EXECI;
                        OP_BEQ:       r_state <= S_BEQ;
                        OP_JAL:       r_state <= S_JAL;
                        default: begin
                            r_state <= S_TRAP;
                            r_trap  <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: r_state <= op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMWB:  r_state <= S_FETCH;
                S_EXECR:  r_state <= S_ALUWB;
                S_EXECI:  r_state <= S_ALUWB;
                S_ALUWB:  r_state <= S_FETCH;
                S_BEQ:    r_state <= S_FETCH;
                S_JAL:    r_state <= S_ALUWB;
                default:  r_state <= S_TRAP;
            endcase
        end
    end

    always_comb begin
        w_alu_dec = 3'b000;
        case (funct3)
            3'b000:  w_alu_dec = (op[5] & funct7b5) ? 3'b001 : 3'b000;
            3'b010:  w_alu_dec = 3'b101;
            3'b110:  w_alu_dec = 3'b011;
            3'b111:  w_alu_dec = 3'b010;
            default: w_alu_dec = 3'b000;
        endcase
    end

    always_comb begin
        immsrc = 2'b00;
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    always_comb begin
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        alucontrol = 3'b000;
        resultsrc  = 2'b00;
        adrsrc     = 1'b0;
        memreq     = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        regwrite   = 1'b0;
        case (r_state)
            S_FETCH: begin
                memreq    = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = mem_ready;
                pcwrite   = mem_ready;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            S_MEMREAD: begin
                memreq = 1'b1;
                adrsrc = 1'b1;
            end
            S_MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                memreq   = 1'b1;
                memwrite = 1'b1;
                adrsrc   = 1'b1;
            end
            S_EXECR: begin
                alusrca    = 2'b10;
                alucontrol = w_alu_dec;
            end
            S_EXECI: begin
                alusrca    = 2'b10;
                alusrcb    = 2'b01;
                alucontrol = w_alu_dec;
            end
            S_ALUWB: regwrite = 1'b1;
            S_BEQ: begin
                alusrca    = 2'b10;
                alucontrol = 3'b001;
                pcwrite    = zero;
            end
            S_JAL: begin
                alusrca = 2'b01;
                alusrcb = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        // Reset holds the state in FETCH, so gate every strobe to keep the datapath quiet.
        if (!rst_n) begin
            memreq   = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            regwrite = 1'b0;
        end
    end

    assign trap = r_trap;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;
    localparam int         TMO    = 4;

    typedef struct packed {
        logic       memreq, memwrite, adrsrc, irwrite, pcwrite, regwrite, trap;
        logic [1:0] resultsrc, alusrca, alusrcb;
        logic [2:0] alucontrol;
        logic [1:0] immsrc;
    } ctl_t;

    typedef struct {
        logic rdy;
        ctl_t ctl;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic [1:0] immsrc1, alusrca1, alusrcb1, resultsrc1;
    logic [2:0] alucontrol1;
    logic       adrsrc1, memreq1, memwrite1, irwrite1, pcwrite1, regwrite1, trap1;
    logic [1:0] immsrc2, alusrca2, alusrcb2, resultsrc2;
    logic [2:0] alucontrol2;
    logic       adrsrc2, memreq2, memwrite2, irwrite2, pcwrite2, regwrite2, trap2;

    multicycle_controller #(.MEM_TIMEOUT(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .immsrc(immsrc1), .alusrca(alusrca1),
        .alusrcb(alusrcb1), .alucontrol(alucontrol1), .resultsrc(resultsrc1),
        .adrsrc(adrsrc1), .memreq(memreq1), .memwrite(memwrite1), .irwrite(irwrite1),
        .pcwrite(pcwrite1), .regwrite(regwrite1), .trap(trap1)
    );

    multicycle_controller #(.MEM_TIMEOUT(TMO)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .immsrc(immsrc2), .alusrca(alusrca2),
        .alusrcb(alusrcb2), .alucontrol(alucontrol2), .resultsrc(resultsrc2),
        .adrsrc(adrsrc2), .memreq(memreq2), .memwrite(memwrite2), .irwrite(irwrite2),
        .pcwrite(pcwrite2), .regwrite(regwrite2), .trap(trap2)
    );

    always #5 clk = ~clk;

    ctl_t got1, got2;
    always_comb begin
        got1 = {memreq1, memwrite1, adrsrc1, irwrite1, pcwrite1, regwrite1, trap1,
                resultsrc1, alusrca1, alusrcb1, alucontrol1, immsrc1};
        got2 = {memreq2, memwrite2, adrsrc2, irwrite2, pcwrite2, regwrite2, trap2,
                resultsrc2, alusrca2, alusrcb2, alucontrol2, immsrc2};
    end

    int    checks = 0;
    int    errors = 0;
    bit    active = 1'b0;
    ctl_t  exp1_q[$];
    ctl_t  exp2_q[$];
    step_t steps[$];
    bit    t2_trapped = 1'b0;
    int    t2_streak = 0;

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == OP_SW)  return 2'b01;
        if (o == OP_BEQ) return 2'b10;
        if (o == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic is_sub);
        case (f3)
            3'b000:  return is_sub ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic ctl_t idle(input logic [1:0] im);
        ctl_t c = '0;
        c.immsrc = im;
        return c;
    endfunction

    function automatic void push(input logic r, input ctl_t c);
        steps.push_back('{rdy: r, ctl: c});
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(1, 0));
    endfunction

    // Reference: expected control word per cycle of one instruction, plus the mem_ready to drive.
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input int fw, input int mw, input int ntrap);
        ctl_t c;
        logic [1:0] im = imm_of(o);
        steps.delete();
        c = idle(im); c.memreq = 1; c.alusrcb = 2'b10; c.resultsrc = 2'b10;
        repeat (fw) push(1'b0, c);
        c.irwrite = 1; c.pcwrite = 1;
        push(1'b1, c);
        c = idle(im); c.alusrca = 2'b01; c.alusrcb = 2'b01;
        push(rnd(), c);
        case (o)
            OP_LW, OP_SW: begin
                c = idle(im); c.alusrca = 2'b10; c.alusrcb = 2'b01;
                push(rnd(), c);
                c = idle(im); c.memreq = 1; c.adrsrc = 1; c.memwrite = (o == OP_SW);
                repeat (mw) push(1'b0, c);
                push(1'b1, c);
                if (o == OP_LW) begin
                    c = idle(im); c.resultsrc = 2'b01; c.regwrite = 1;
                    push(rnd(), c);
                end
            end
            OP_R, OP_I: begin
                c = idle(im); c.alusrca = 2'b10;
                c.alusrcb = (o == OP_I) ? 2'b01 : 2'b00;
                c.alucontrol = alu_ref(f3, (o == OP_R) && f7);
                push(rnd(), c);
                c = idle(im); c.regwrite = 1;
                push(rnd(), c);
            end
            OP_BEQ: begin
                c = idle(im); c.alusrca = 2'b10; c.alucontrol = 3'b001; c.pcwrite = z;
                push(rnd(), c);
            end
            OP_JAL: begin
                c = idle(im); c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcwrite = 1;
                push(rnd(), c);
                c = idle(im); c.regwrite = 1;
                push(rnd(), c);
            end
            default: begin
                c = idle(im); c.trap = 1;
                repeat (ntrap) push(rnd(), c);
            end
        endcase
    endtask

    // DUT2 follows DUT1 until TMO consecutive unanswered memory requests, then holds trap.
    task automatic run_steps(input int max_steps);
        ctl_t t;
        for (int i = 0; i < steps.size() && i < max_steps; i++) begin
            mem_ready = steps[i].rdy;
            exp1_q.push_back(steps[i].ctl);
            if (t2_trapped) begin
                t = idle(imm_of(op)); t.trap = 1;
                exp2_q.push_back(t);
            end else begin
                exp2_q.push_back(steps[i].ctl);
                if (steps[i].ctl.memreq && !steps[i].rdy) t2_streak++;
                else t2_streak = 0;
                if (t2_streak == TMO) t2_trapped = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw, input int max_steps);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        build(o, f3, f7, z, fw, mw, 20);
        run_steps(max_steps);
    endtask

    task automatic chk(input string name, input ctl_t got, input ctl_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Asserts rst_n mid-cycle; strobes must drop at once and stay low until release.
    task automatic apply_reset(input int ncyc);
        ctl_t r;
        rst_n = 1'b0;
        exp1_q.delete();
        exp2_q.delete();
        t2_trapped = 1'b0;
        t2_streak = 0;
        r = idle(imm_of(op)); r.alusrcb = 2'b10; r.resultsrc = 2'b10;
        #1;
        chk("reset_async_dut1", got1, r);
        chk("reset_async_dut2", got2, r);
        repeat (ncyc) begin
            @(negedge clk);
            chk("reset_hold_dut1", got1, r);
            chk("reset_hold_dut2", got2, r);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (active && rst_n) begin
            checks += 2;
            if (exp1_q.size() == 0 || exp2_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow sizes=%0d/%0d t=%0t",
                         exp1_q.size(), exp2_q.size(), $time);
            end else begin
                ctl_t e1, e2;
                e1 = exp1_q.pop_front();
                e2 = exp2_q.pop_front();
                if (got1 !== e1) begin
                    errors++;
                    $display("FAIL ctl_dut1 got=%h expected=%h t=%0t", got1, e1, $time);
                end
                if (got2 !== e2) begin
                    errors++;
                    $display("FAIL ctl_dut2 got=%h expected=%h t=%0t", got2, e2, $time);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        logic [6:0] ops [6];
        ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
        @(posedge clk); #1;
        active = 1'b1;
        apply_reset(3);

        run_instr(OP_LW,  3'b000, 1'b0, 1'b0, 2, 1, 99);
        run_instr(OP_SW,  3'b010, 1'b0, 1'b0, 0, 0, 99);
        run_instr(OP_R,   3'b000, 1'b1, 1'b0, 0, 0, 99);
        run_instr(OP_I,   3'b000, 1'b1, 1'b0, 0, 0, 99);
        run_instr(OP_R,   3'b010, 1'b0, 1'b0, 0, 0, 99);
        run_instr(OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0, 99);
        run_instr(OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0, 99);
        run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0, 99);
        run_instr(OP_LW,  3'b000, 1'b0, 1'b0, TMO - 1, TMO - 1, 99);

        for (int i = 0; i < 60; i++) begin
            run_instr(ops[$urandom_range(5, 0)], 3'($urandom_range(7, 0)),
                      1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                      $urandom_range(TMO - 1, 0), $urandom_range(TMO - 1, 0), 99);
        end

        run_instr(OP_LW, 3'b000, 1'b0, 1'b0, TMO + 2, 0, 99);
        apply_reset(2);
        run_instr(OP_SW, 3'b000, 1'b0, 1'b0, 1, TMO + 3, 99);
        apply_reset(2);

        run_instr(OP_BAD, 3'b000, 1'b0, 1'b0, 0, 0, 99);
        apply_reset(2);

        run_instr(OP_LW, 3'b000, 1'b0, 1'b0, 0, 3, 5);
        mem_ready = 1'b1;
        #2;
        apply_reset(3);
        run_instr(OP_SW, 3'b000, 1'b0, 1'b0, 0, 0, 99);
        run_instr(OP_I,  3'b111, 1'b0, 1'b0, 1, 0, 99);

        active = 1'b0;
        checks++;
        if (exp1_q.size() != 0 || exp2_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d/%0d expected=0", exp1_q.size(), exp2_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
